// File: rtl/sccb_master.sv
// SCCB 3-phase write master: accepts one {reg, data} request and
// shifts out {DEV_ADDR, reg, data}, each byte followed by a released 9th bit.
// Optional macro SCCB_ACK_CHECK_EN: samples the 9th bits and sets a
// sticky ack_err on NACK; when undefined ack_err is 0 and sio_d_i is unused.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake, req_data = {reg[7:0], data[7:0]}
//   busy, done, ack_err : status (busy outside IDLE, done at STOP end)
//   sio_c, sio_d_oe     : SCCB clock, SIO_D pull-low enable
//   sio_d_i             : sampled SIO_D level
module sccb_master #(
  parameter int          QTR_CYCLES = 125,
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter int          GAP_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        sio_c,
  output logic        sio_d_oe,
  input  logic        sio_d_i
);

  localparam int CNT_MAX =
    (QTR_CYCLES > GAP_CYCLES) ? QTR_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] QTR_LAST = CW'(QTR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [4:0]    LAST_IDX = 5'd26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_A,
    S_START_B,
    S_BIT,
    S_STOP_A,
    S_STOP_B,
    S_STOP_C,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [4:0]    idx_q, idx_d;
  logic [26:0]   shift_q, shift_d;
  logic          sio_c_q, sio_c_d;
  logic          sio_d_oe_q, sio_d_oe_d;

  logic qtr_end;
  logic gap_end;
  logic accept;

  assign qtr_end   = (cnt_q == QTR_LAST);
  assign gap_end   = (cnt_q == GAP_LAST);
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_STOP_C) && qtr_end;
  assign sio_c     = sio_c_q;
  assign sio_d_oe  = sio_d_oe_q;

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = qtr_end ? '0 : cnt_q + CW'(1);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          shift_d = {DEV_ADDR, 1'b1,
                     req_data[15:8], 1'b1,
                     req_data[7:0], 1'b1};
          qtr_d   = '0;
          idx_d   = '0;
          state_d = S_START_A;
        end
      end
      S_START_A: begin
        if (qtr_end) state_d = S_START_B;
      end
      S_START_B: begin
        if (qtr_end) state_d = S_BIT;
      end
      S_BIT: begin
        if (qtr_end) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            shift_d = {shift_q[25:0], 1'b0};
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = S_STOP_A;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
      end
      S_STOP_A: begin
        if (qtr_end) state_d = S_STOP_B;
      end
      S_STOP_B: begin
        if (qtr_end) state_d = S_STOP_C;
      end
      S_STOP_C: begin
        if (qtr_end) state_d = S_GAP;
      end
      S_GAP: begin
        cnt_d = gap_end ? '0 : cnt_q + CW'(1);
        if (gap_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin levels are decoded from the next state and registered so the
  // camera pins never see decode glitches from the counters.
  always_comb begin
    sio_c_d    = 1'b1;
    sio_d_oe_d = 1'b0;
    unique case (state_d)
      S_IDLE, S_START_A, S_GAP: begin
        sio_c_d    = 1'b1;
        sio_d_oe_d = 1'b0;
      end
      S_START_B: begin
        sio_c_d    = 1'b1;
        sio_d_oe_d = 1'b1;
      end
      S_BIT: begin
        // q0/q1 low, q2/q3 high; data set up while SCL is low
        sio_c_d    = qtr_d[1];
        sio_d_oe_d = ~shift_d[26];
      end
      S_STOP_A: begin
        sio_c_d    = 1'b0;
        sio_d_oe_d = 1'b1;
      end
      S_STOP_B: begin
        sio_c_d    = 1'b1;
        sio_d_oe_d = 1'b1;
      end
      S_STOP_C: begin
        sio_c_d    = 1'b1;
        sio_d_oe_d = 1'b0;
      end
      default: begin
        sio_c_d    = 1'b1;
        sio_d_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      qtr_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      sio_c_q    <= 1'b1;
      sio_d_oe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      sio_c_q    <= sio_c_d;
      sio_d_oe_q <= sio_d_oe_d;
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  logic ack_err_q, ack_err_d;
  logic ack_slot;

  // First cycle of q2 of each ninth bit: SCL is high on the pin.
  assign ack_slot = (state_q == S_BIT) && (qtr_q == 2'd2) &&
                    (cnt_q == '0) &&
                    ((idx_q == 5'd8) || (idx_q == 5'd17) ||
                     (idx_q == LAST_IDX));

  always_comb begin
    ack_err_d = ack_err_q;
    if (ack_slot && sio_d_i) ack_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ack_err_q <= 1'b0;
    else     ack_err_q <= ack_err_d;
  end

  assign ack_err = ack_err_q;
`else
  logic unused_sio_d_i;
  assign unused_sio_d_i = sio_d_i;
  assign ack_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master: bus monitor decodes SIO_C/SIO_D,
// slave model drives ACKs; one main instance plus a QTR=1/GAP=1 corner.
module tb_sccb_master;

  localparam int Q   = 4;
  localparam int G   = 8;
  localparam int TXN = 113 * Q + G;
  localparam int TXN_C = 113 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_data = '0;
  logic        sel = 1'b0;
  int          slave_mode = 1;

  logic rdy0, busy0, done0, ack0, c0, oe0;
  logic rdy1, busy1, done1, ack1, c1, oe1;
  logic sio_d_i;
  logic pull;

  logic rdy, busy, done, ack, c, oe, d;
  assign rdy  = sel ? rdy1  : rdy0;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign ack  = sel ? ack1  : ack0;
  assign c    = sel ? c1    : c0;
  assign oe   = sel ? oe1   : oe0;
  assign d       = ~oe & ~pull;
  assign sio_d_i = d;

  sccb_master #(.QTR_CYCLES(Q), .DEV_ADDR(8'h42), .GAP_CYCLES(G)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(rdy0),
    .req_data(req_data),
    .busy(busy0), .done(done0), .ack_err(ack0),
    .sio_c(c0), .sio_d_oe(oe0), .sio_d_i(sio_d_i)
  );

  sccb_master #(.QTR_CYCLES(1), .DEV_ADDR(8'h42), .GAP_CYCLES(1)) u_corner (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(rdy1),
    .req_data(req_data),
    .busy(busy1), .done(done1), .ack_err(ack1),
    .sio_c(c1), .sio_d_oe(oe1), .sio_d_i(sio_d_i)
  );

  int checks = 0;
  int failures = 0;

  // bus monitor and slave state (written only by the monitor process)
  logic        prev_c = 1'b1, prev_d = 1'b1, prev_oe = 1'b0;
  logic        in_xfer = 1'b0;
  int          nbits = 0, rises = 0, falls = 0;
  logic [26:0] sr = '0;
  int          mon_cnt = 0;
  logic [15:0] mon_data [0:63];
  logic [7:0]  mon_dev  [0:63];
  int          mon_rises[0:63];
  int          hi_toggles = 0, slot_viol = 0, done_cnt = 0;
  int          gap_run = 0, last_gap = -1;
  logic        gap_on = 1'b0;
  int          idle_run = 0, last_idle = -1;

  // slave drives its ACK after SCL falls into a ninth bit
  always_comb begin
    pull = 1'b0;
    if (in_xfer) begin
      if (slave_mode == 1)
        pull = (falls == 9) || (falls == 18) || (falls == 27);
      else if (slave_mode == 2)
        pull = (falls == 9) || (falls == 18);
    end
  end

  always @(negedge clk) begin
    if (prev_c && c && (prev_oe != oe)) hi_toggles++;
    if (prev_c && c && prev_d && !d) begin
      in_xfer = 1'b1;
      nbits = 0;
      rises = 0;
      falls = 0;
    end else if (prev_c && c && !prev_d && d && in_xfer) begin
      if (mon_cnt < 64) begin
        mon_data[mon_cnt]  = {sr[17:10], sr[8:1]};
        mon_dev[mon_cnt]   = sr[26:19];
        mon_rises[mon_cnt] = rises;
        mon_cnt++;
      end
      in_xfer = 1'b0;
    end
    if (!prev_c && c && in_xfer) begin
      rises++;
      if (nbits < 27) begin
        sr = {sr[25:0], d};
        if ((nbits == 8 || nbits == 17 || nbits == 26) && oe)
          slot_viol++;
        nbits++;
      end
    end
    if (prev_c && !c && in_xfer) falls++;
    if (rst) in_xfer = 1'b0;
    if (done) begin
      done_cnt++;
      gap_on = 1'b1;
      gap_run = 0;
    end else if (gap_on) begin
      if (busy) gap_run++;
      else begin
        last_gap = gap_run;
        gap_on = 1'b0;
      end
    end
    if (busy === 1'b0) idle_run++;
    else if (idle_run > 0) begin
      last_idle = idle_run;
      idle_run = 0;
    end
    prev_c  = c;
    prev_d  = d;
    prev_oe = oe;
  end

  // Issue one request; cyc = cycles busy after the accept edge.
  task automatic do_write(input logic [15:0] wd, output int cyc);
    int w = 0;
    while (!rdy && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL ready_timeout got=%b exp=1", rdy);
    end
    req_valid = 1'b1;
    req_data  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = ~wd;
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({c, oe, rdy, busy, done, ack} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_vals got=%b exp=100000",
               {c, oe, rdy, busy, done, ack});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", rdy);
    end
  endtask

  task automatic test_single();
    int m0 = mon_cnt, d0 = done_cnt, t0 = hi_toggles, cyc;
    do_write(16'h1280, cyc);
    checks++;
    if (cyc !== TXN) begin
      failures++;
      $display("FAIL single_len got=%0d exp=%0d", cyc, TXN);
    end
    checks++;
    if (mon_data[m0] !== 16'h1280 || mon_cnt !== m0 + 1) begin
      failures++;
      $display("FAIL single_data got=%h n=%0d exp=1280 n=%0d",
               mon_data[m0], mon_cnt - m0, 1);
    end
    checks++;
    if (mon_dev[m0] !== 8'h42) begin
      failures++;
      $display("FAIL single_dev got=%h exp=42", mon_dev[m0]);
    end
    checks++;
    if (mon_rises[m0] !== 28) begin
      failures++;
      $display("FAIL single_rises got=%0d exp=28", mon_rises[m0]);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL single_done got=%0d exp=1", done_cnt - d0);
    end
    checks++;
    if (hi_toggles - t0 !== 2) begin
      failures++;
      $display("FAIL single_hi_toggles got=%0d exp=2", hi_toggles - t0);
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL single_ready_back got=%b exp=1", rdy);
    end
  endtask

  task automatic test_back_to_back();
    int m0 = mon_cnt, d0 = done_cnt, cyc1 = 0, cyc2 = 0, w = 0;
    req_valid = 1'b1;
    req_data  = 16'h3A04;
    while (!rdy && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    req_data = 16'h40D0;
    while (busy && cyc1 < 5000) begin
      @(posedge clk); #1;
      cyc1++;
    end
    checks++;
    if (rdy !== 1'b1 || cyc1 !== TXN) begin
      failures++;
      $display("FAIL b2b_first got=%0d rdy=%b exp=%0d rdy=1",
               cyc1, rdy, TXN);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (busy && cyc2 < 5000) begin
      @(posedge clk); #1;
      cyc2++;
    end
    checks++;
    if (cyc2 !== TXN) begin
      failures++;
      $display("FAIL b2b_second_len got=%0d exp=%0d", cyc2, TXN);
    end
    checks++;
    if (mon_data[m0] !== 16'h3A04 || mon_data[m0+1] !== 16'h40D0) begin
      failures++;
      $display("FAIL b2b_data got=%h,%h exp=3a04,40d0",
               mon_data[m0], mon_data[m0+1]);
    end
    checks++;
    if (last_idle !== 1) begin
      failures++;
      $display("FAIL b2b_idle got=%0d exp=1", last_idle);
    end
    checks++;
    if (last_gap !== G) begin
      failures++;
      $display("FAIL b2b_gap got=%0d exp=%0d", last_gap, G);
    end
    checks++;
    if (done_cnt - d0 !== 2) begin
      failures++;
      $display("FAIL b2b_done got=%0d exp=2", done_cnt - d0);
    end
  endtask

  task automatic test_random();
    int m0 = mon_cnt, t0 = hi_toggles, s0 = slot_viol, cyc;
    logic [15:0] wd;
    for (int i = 0; i < 10; i++) begin
      wd = 16'($urandom);
      do_write(wd, cyc);
      checks++;
      if (mon_data[m0+i] !== wd || mon_rises[m0+i] !== 28) begin
        failures++;
        $display("FAIL rand_data[%0d] got=%h r=%0d exp=%h r=28",
                 i, mon_data[m0+i], mon_rises[m0+i], wd);
      end
    end
    checks++;
    if (hi_toggles - t0 !== 20) begin
      failures++;
      $display("FAIL rand_hi_toggles got=%0d exp=20", hi_toggles - t0);
    end
    checks++;
    if (slot_viol - s0 !== 0) begin
      failures++;
      $display("FAIL rand_slot_oe got=%0d exp=0", slot_viol - s0);
    end
  endtask

  task automatic test_reset_mid();
    int m0, cyc, w = 0;
    req_valid = 1'b1;
    req_data  = 16'hABCD;
    while (!rdy && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (220) @(posedge clk);
    #1;
    checks++;
    if (rises !== 13) begin
      failures++;
      $display("FAIL mid_position got=%0d exp=13", rises);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({c, oe, busy, rdy, ack} !== 5'b10010) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=10010", {c, oe, busy, rdy, ack});
    end
    m0 = mon_cnt;
    do_write(16'h1100, cyc);
    checks++;
    if (mon_data[m0] !== 16'h1100 || mon_cnt !== m0 + 1) begin
      failures++;
      $display("FAIL mid_after got=%h n=%0d exp=1100 n=1",
               mon_data[m0], mon_cnt - m0);
    end
  endtask

  task automatic test_ack();
    int cyc;
    slave_mode = 2;
    do_write(16'h0A55, cyc);
`ifdef SCCB_ACK_CHECK_EN
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL ack_nack got=%b exp=1", ack);
    end
    slave_mode = 1;
    do_write(16'h0B66, cyc);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL ack_sticky got=%b exp=1", ack);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_write(16'h0C77, cyc);
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_full got=%b exp=0", ack);
    end
`else
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_tied got=%b exp=0", ack);
    end
`endif
    slave_mode = 1;
  endtask

  task automatic test_corner();
    int m0, d0, cyc;
    @(posedge clk); #1;
    sel = 1'b1;
    @(posedge clk); #1;
    m0 = mon_cnt;
    d0 = done_cnt;
    do_write(16'hC5A3, cyc);
    checks++;
    if (cyc !== TXN_C) begin
      failures++;
      $display("FAIL corner_len got=%0d exp=%0d", cyc, TXN_C);
    end
    checks++;
    if (mon_data[m0] !== 16'hC5A3 || mon_rises[m0] !== 28) begin
      failures++;
      $display("FAIL corner_data got=%h r=%0d exp=c5a3 r=28",
               mon_data[m0], mon_rises[m0]);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL corner_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_ack();
    test_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
